// File: rtl/io_bus_pkg.sv
// Shared encodings and field widths for the host-to-I/O bus master.
// Kept separate so the master and its timeout counter agree on widths and codes.
package io_bus_pkg;

  localparam int unsigned SEL_W  = 12;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StWrite    = 2'd1;
  localparam logic [1:0] StReadWait = 2'd2;
  localparam logic [1:0] StResp     = 2'd3;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrDecode  = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  function automatic logic addr_hit(input logic [SEL_W+ADDR_W-1:0] addr,
                                    input logic [SEL_W-1:0]        base);
    return addr[SEL_W+ADDR_W-1 -: SEL_W] == base;
  endfunction

endpackage

// File: rtl/io_bus_timeout_counter.sv
// Free-running wait counter with synchronous clear; tc flags the last permitted wait cycle.
// Clear dominates enable so a new read always starts counting from zero.
module io_bus_timeout_counter
  import io_bus_pkg::*;
#(
  parameter int unsigned TERMINAL = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  // High during the TERMINAL-th enabled cycle, so the wait lasts exactly TERMINAL cycles.
  assign tc = (count_q == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/io_bus_master.sv
// Single-outstanding host command to I/O strobe bridge with decode, write hold and read timeout.
// Every output is a flop loaded from the next state, so strobes appear one cycle after accept.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter logic [SEL_W-1:0] SLAVE_BASE = 12'h000,
  parameter int unsigned      WR_CYCLES  = 2,
  parameter int unsigned      TIMEOUT    = 255
) (
  input  logic              io_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [31:0]       cmd_addr,
  input  logic [DATA_W-1:0] cmd_wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  output logic              io_sel,
  output logic              io_sync,
  output logic [ADDR_W-1:0] io_addr,
  output logic              io_rd_en,
  output logic              io_wr_en,
  output logic [DATA_W-1:0] io_wr_data,
  input  logic [DATA_W-1:0] io_rd_data,
  input  logic              io_rd_ack
);

  localparam logic [3:0] WrLast = 4'(WR_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic [1:0]        rsp_err_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic [ADDR_W-1:0] io_addr_d;
  logic [DATA_W-1:0] io_wr_data_d;
  logic              accept, hit, bus_active_d, cnt_tc;

  assign accept       = (state_q == StIdle) && cmd_valid && cmd_ready;
  assign hit          = addr_hit(cmd_addr, SLAVE_BASE);
  assign bus_active_d = (state_d == StWrite) || (state_d == StReadWait);

  io_bus_timeout_counter #(
    .TERMINAL (TIMEOUT)
  ) u_timeout (
    .clk    (io_clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state_q == StReadWait),
    .tc     (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rsp_err_d  = rsp_err;
    rsp_data_d = rsp_data;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (!hit) begin
            state_d    = StResp;
            rsp_err_d  = ErrDecode;
            rsp_data_d = '0;
          end else if (cmd_wr) begin
            state_d  = StWrite;
            wr_cnt_d = '0;
          end else begin
            state_d = StReadWait;
          end
        end
      end
      StWrite: begin
        if (wr_cnt_q == WrLast) begin
          state_d    = StResp;
          rsp_err_d  = ErrOk;
          rsp_data_d = '0;
        end else begin
          wr_cnt_d = wr_cnt_q + 4'd1;
        end
      end
      StReadWait: begin
        // An ack arriving in the terminal cycle still counts as a successful read.
        if (io_rd_ack) begin
          state_d    = StResp;
          rsp_err_d  = ErrOk;
          rsp_data_d = io_rd_data;
        end else if (cnt_tc) begin
          state_d    = StResp;
          rsp_err_d  = ErrTimeout;
          rsp_data_d = '0;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d    = StIdle;
          rsp_err_d  = ErrOk;
          rsp_data_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    io_addr_d    = io_addr;
    io_wr_data_d = io_wr_data;
    if (!bus_active_d) begin
      io_addr_d = '0;
    end else if (accept) begin
      io_addr_d = cmd_addr[ADDR_W-1:0];
    end
    if (state_d != StWrite) begin
      io_wr_data_d = '0;
    end else if (accept) begin
      io_wr_data_d = cmd_wr_data;
    end
  end

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_cnt_q   <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= '0;
      io_sel     <= 1'b0;
      io_sync    <= 1'b0;
      io_addr    <= '0;
      io_rd_en   <= 1'b0;
      io_wr_en   <= 1'b0;
      io_wr_data <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      cmd_ready  <= (state_d == StIdle);
      rsp_valid  <= (state_d == StResp);
      rsp_data   <= rsp_data_d;
      rsp_err    <= rsp_err_d;
      io_sel     <= bus_active_d;
      io_sync    <= bus_active_d;
      io_addr    <= io_addr_d;
      io_rd_en   <= (state_d == StReadWait);
      io_wr_en   <= (state_d == StWrite);
      io_wr_data <= io_wr_data_d;
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Randomised and directed bench for io_bus_master against a transaction-level reference model.
// The model predicts error code, response data and strobe-cycle count per command.
module tb_io_bus_master;

  localparam int          WR_CYCLES = 2;
  localparam int          TIMEOUT   = 16;
  localparam logic [11:0] BASE      = 12'h000;

  logic        io_clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wr_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        io_sel, io_sync, io_rd_en, io_wr_en, io_rd_ack;
  logic [19:0] io_addr;
  logic [31:0] io_wr_data, io_rd_data;

  int checks = 0;
  int errors = 0;

  io_bus_master #(
    .SLAVE_BASE (BASE),
    .WR_CYCLES  (WR_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .io_clk      (io_clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wr_data (cmd_wr_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .io_sel      (io_sel),
    .io_sync     (io_sync),
    .io_addr     (io_addr),
    .io_rd_en    (io_rd_en),
    .io_wr_en    (io_wr_en),
    .io_wr_data  (io_wr_data),
    .io_rd_data  (io_rd_data),
    .io_rd_ack   (io_rd_ack)
  );

  always #5 io_clk = ~io_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction-level outcome: error code, response data, cycles the bus is strobed.
  function automatic void model(input logic wr, input logic [31:0] addr, input logic [31:0] rdata,
                                input int ack_at, output logic [1:0] err,
                                output logic [31:0] data, output int strobes);
    if (addr[31:20] != BASE) begin
      err = 2'b01; data = '0; strobes = 0;
    end else if (wr) begin
      err = 2'b00; data = '0; strobes = WR_CYCLES;
    end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
      err = 2'b00; data = rdata; strobes = ack_at;
    end else begin
      err = 2'b10; data = '0; strobes = TIMEOUT;
    end
  endfunction

  function automatic logic any_out();
    return |{cmd_ready, rsp_valid, rsp_data, rsp_err, io_sel, io_sync, io_addr, io_rd_en,
             io_wr_en, io_wr_data};
  endfunction

  task automatic wait_ready(input string name);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      @(negedge io_clk);
      k++;
    end
    check({name, " cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  // ack_at: strobe cycle (1-based) in which the slave acks a read; 0 means never.
  task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata,
                         input int hold);
    logic [1:0]  e_err;
    logic [31:0] e_data;
    int          e_strobes, strobes, sel_seen, k;
    bit          done;
    model(wr, addr, rdata, ack_at, e_err, e_data, e_strobes);
    wait_ready(name);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wr_data = wdata;
    @(negedge io_clk);
    cmd_valid = 1'b0; cmd_wr = 1'($urandom); cmd_addr = $urandom; cmd_wr_data = $urandom;
    strobes = 0; sel_seen = 0; done = 1'b0;
    for (k = 1; k <= TIMEOUT + 8 && !done; k++) begin
      if (rsp_valid) begin
        done = 1'b1;
        check({name, " latency"}, 32'(k), 32'(e_strobes + 1));
      end else begin
        if (io_sync) strobes++;
        if (io_sel) sel_seen++;
        check({name, " sync_wo_sel/rd_and_wr"},
              32'({io_sync & ~io_sel, io_rd_en & io_wr_en}), 32'd0);
        if (io_sync) begin
          check({name, " io_addr"}, 32'(io_addr), 32'(addr[19:0]));
          check({name, " dir"}, 32'({io_wr_en, io_rd_en}), wr ? 32'd2 : 32'd1);
          if (wr) check({name, " io_wr_data"}, io_wr_data, wdata);
        end else begin
          check({name, " idle bus zero"}, 32'(io_addr) | io_wr_data, 32'd0);
        end
        if (io_rd_en && !wr && k == ack_at) begin
          io_rd_ack = 1'b1; io_rd_data = rdata;
        end else if (io_rd_en) begin
          io_rd_ack = 1'b0; io_rd_data = $urandom;
        end else begin
          io_rd_ack = 1'($urandom); io_rd_data = $urandom;
        end
        @(negedge io_clk);
      end
    end
    io_rd_ack = 1'b0;
    check({name, " rsp arrived"}, 32'(done), 32'd1);
    check({name, " strobe cycles"}, 32'(strobes), 32'(e_strobes));
    check({name, " sel cycles"}, 32'(sel_seen), 32'(e_strobes));
    check({name, " rsp_err"}, 32'(rsp_err), 32'(e_err));
    check({name, " rsp_data"}, rsp_data, e_data);
    for (int i = 0; i < hold; i++) begin
      io_rd_ack = 1'($urandom); io_rd_data = $urandom;
      @(negedge io_clk);
      check({name, " hold"}, {rsp_data ^ e_data},  32'd0);
      check({name, " hold flags"}, 32'({rsp_valid, rsp_err, cmd_ready, io_sync}),
            32'({1'b1, e_err, 1'b0, 1'b0}));
    end
    io_rd_ack = 1'b0;
    rsp_ready = 1'b1;
    @(negedge io_clk);
    rsp_ready = 1'b0;
    check({name, " post-handshake"}, 32'({rsp_valid, cmd_ready}), 32'b01);
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wr_data = '0;
    rsp_ready = 1'b0; io_rd_ack = 1'b0; io_rd_data = '0;
    repeat (2) @(negedge io_clk);
    check("reset outputs", 32'(any_out()), 32'd0);
    reset = 1'b0;
    check("cmd_ready held low until edge", 32'(cmd_ready), 32'd0);
    @(negedge io_clk);
    check("cmd_ready after reset", 32'(cmd_ready), 32'd1);

    run_txn("write", 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 0, 32'h0, 0);
    run_txn("read", 1'b0, 32'h0002_0010, 32'h0, 5, 32'hCAFE_F00D, 0);
    run_txn("timeout", 1'b0, 32'h0003_0000, 32'h0, 0, 32'h0, 0);
    run_txn("miss", 1'b1, 32'h0010_0000, 32'h1111_2222, 0, 32'h0, 0);
    run_txn("ack_at_tc", 1'b0, 32'h000F_FFFC, 32'h0, TIMEOUT, 32'h1234_5678, 10);

    // Reset in the middle of a read wait must drop everything at once.
    wait_ready("rst_mid");
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h0004_0008; io_rd_ack = 1'b0;
    @(negedge io_clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge io_clk);
    check("rst_mid active", 32'({io_sync, io_rd_en}), 32'b11);
    #2 reset = 1'b1;
    #1 check("rst_mid outputs", 32'(any_out()), 32'd0);
    @(negedge io_clk);
    reset = 1'b0;
    @(negedge io_clk);
    check("rst_mid idle", 32'({cmd_ready, rsp_valid, io_sync}), 32'b100);
    run_txn("read after rst", 1'b0, 32'h0004_0008, 32'h0, 3, 32'h0BAD_CAFE, 1);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[31:20] = BASE;
      else if (a[31:20] == BASE) a[31:20] = 12'hFFF;
      run_txn("random", 1'($urandom), a, $urandom, int'($urandom_range(TIMEOUT + 2)),
              $urandom, int'($urandom_range(3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
